// File: rtl/countdown_timer.sv
// Loadable N-bit down-counter with pause, abort and optional auto-reload.
// q and done are registered; busy is decoded from the FSM state.
module countdown_timer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] load_val,
  input  logic         enable,
  input  logic         periodic,
  input  logic         abort,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [N-1:0] C_ZERO = '0;
  localparam logic [N-1:0] C_ONE  = N'(1);

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_q;
  logic [N-1:0] w_q_next;
  logic [N-1:0] r_reload;
  logic [N-1:0] w_reload_next;
  logic         r_done;
  logic         w_done_next;
  logic         w_load;

  assign w_load = start && (load_val != C_ZERO);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values present before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_q      <= C_ZERO;
      r_reload <= C_ZERO;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_q      <= w_q_next;
      r_reload <= w_reload_next;
      r_done   <= w_done_next;
    end
  end

  // NOTE: every signal gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_q_next      = r_q;
    w_reload_next = r_reload;
    w_done_next   = 1'b0;

    if (abort) begin
      w_state_next = S_IDLE;
      w_q_next     = C_ZERO;
    end else if (w_load) begin
      w_state_next  = S_RUN;
      w_q_next      = load_val;
      w_reload_next = load_val;
    end else if (!start) begin
      // A start with a zero load value is a complete no-op for this edge.
      unique case (r_state)
        S_RUN: begin
          if (!enable) begin
            w_state_next = S_PAUSE;
          end else if (r_q > C_ONE) begin
            w_q_next = r_q - C_ONE;
          end else if (r_q == C_ONE) begin
            w_done_next = 1'b1;
            if (periodic) begin
              w_q_next = r_reload;
            end else begin
              w_q_next     = C_ZERO;
              w_state_next = S_IDLE;
            end
          end
        end
        S_PAUSE: begin
          if (enable) w_state_next = S_RUN;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  assign q    = r_q;
  assign done = r_done;

endmodule
